// File: rtl/jump_stack.sv
// jump_stack: return-address stack for fetch-side jal/jr prediction.
// A jal pushes its return address (branch address + 2, skipping the delay
// slot); a jr reads the top entry combinationally and pops it at the edge.
// One checkpoint of the pointer state allows rollback on a branch mispredict.
module jump_stack #(
    parameter int ADDRESS_WIDTH = 22,
    parameter int DEPTH         = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_valid,
    input  logic                       i_jal_inst,
    input  logic                       i_jr_inst,
    input  logic [ADDRESS_WIDTH-1:0]   i_branch_address,
    input  logic                       i_checkpoint,
    input  logic                       i_restore,
    output logic [ADDRESS_WIDTH-1:0]   o_jr_target,
    output logic                       o_jr_target_valid,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [ADDRESS_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]            tos;
    logic [PW:0]              count;
    logic [PW-1:0]            ck_tos;
    logic [PW:0]              ck_count;

    logic                     push;
    logic                     pop;
    logic [ADDRESS_WIDTH-1:0] ra;
    logic [PW-1:0]            tos_next;
    logic [PW:0]              count_next;
    logic                     mem_we;
    logic [PW-1:0]            mem_waddr;

    // Next-state pointers and the memory write for this cycle's jal/jr event.
    // A jal+jr pair replaces the top in place, unless the stack is empty,
    // in which case there is nothing to pop and it degenerates to a push.
    always_comb begin
        push       = i_valid & i_jal_inst;
        pop        = i_valid & i_jr_inst;
        ra         = i_branch_address + ADDRESS_WIDTH'(2);
        tos_next   = tos;
        count_next = count;
        mem_we     = 1'b0;
        mem_waddr  = tos;
        if (push && (!pop || count == '0)) begin
            tos_next   = tos + PW'(1);
            mem_waddr  = tos + PW'(1);
            mem_we     = 1'b1;
            count_next = (count == FULL_COUNT) ? count : count + (PW+1)'(1);
        end else if (push && pop) begin
            mem_we    = 1'b1;
            mem_waddr = tos;
        end else if (pop && count != '0) begin
            tos_next   = tos - PW'(1);
            count_next = count - (PW+1)'(1);
        end
    end

    // State update: reset, then restore (which suppresses every other event),
    // then the normal push/pop with an optional snapshot of the result.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            tos      <= '0;
            count    <= '0;
            ck_tos   <= '0;
            ck_count <= '0;
        end else if (i_restore) begin
            tos   <= ck_tos;
            count <= ck_count;
        end else begin
            tos   <= tos_next;
            count <= count_next;
            if (mem_we) begin
                mem[mem_waddr] <= ra;
            end
            if (i_checkpoint) begin
                ck_tos   <= tos_next;
                ck_count <= count_next;
            end
        end
    end

    // Status and prediction outputs depend on registered state only.
    always_comb begin
        o_jr_target       = mem[tos];
        o_jr_target_valid = (count != '0);
        o_empty           = (count == '0);
        o_full            = (count == FULL_COUNT);
        o_count           = count;
    end

endmodule

// File: doc/jump_stack.md
# jump_stack

Return-address stack fed by the fetch-side pre-alignment logic. It pushes a return address when a fetched bundle's first control instruction is a `jal` and supplies a predicted target when it is a `jr`. Fetch can redirect in the same cycle the `jr` is seen. A single checkpoint register lets the pointer state be rolled back when a predicted conditional branch resolves as mispredicted.

## Interface
Parameters:
- ADDRESS_WIDTH, 22, width of word addresses.
- DEPTH, 8, number of entries; must be a power of two, ≥2.

Ports (PW = $clog2(DEPTH)):
- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  reset; synchronous and active-high.
- i_valid  input  1  the bundle's control-instruction flags are valid this cycle (not stalled).
- i_jal_inst  input  1  bundle's first control instruction is `jal`.
- i_jr_inst  input  1  bundle's first control instruction is `jr`.
- i_branch_address  input  ADDRESS_WIDTH  word address of that `jal`/`jr`.
- i_checkpoint  input  1  a conditional branch was predicted this cycle; snapshot the pointer state.
- i_restore  input  1  mispredict; reload the pointer state from the checkpoint.
- o_jr_target  output  ADDRESS_WIDTH  predicted `jr` target (entry at top of stack).
- o_jr_target_valid  output  1  stack non-empty (o_count != 0).
- o_empty  output  1  o_count == 0.
- o_full  output  1  o_count == DEPTH.
- o_count  output  PW+1  number of valid entries.

## Operation
State:
- mem[0..DEPTH-1] of ADDRESS_WIDTH bits.
- tos (PW bits): index of the topmost valid entry.
- count (PW+1 bits).
- Checkpoint pair ck_tos and ck_count.

Reset: mem, tos, count, ck_tos and ck_count all go to 0. Resulting outputs: o_jr_target=0, o_jr_target_valid=0, o_empty=1, o_full=0, o_count=0.

Return address:
- ra = i_branch_address + 2, which skips the delay slot.
- Computed modulo 2^ADDRESS_WIDTH; the carry is dropped.

Events are sampled only when i_valid=1. When i_valid=0, i_jal_inst and i_jr_inst are ignored. i_checkpoint and i_restore act regardless of i_valid.

- **Push** (jal only): tos <= tos+1 mod DEPTH; mem[tos+1] <= ra; count <= min(count+1, DEPTH).
  - When full, the push wraps and silently overwrites the oldest entry. count stays at DEPTH.
- **Pop** (jr only): o_jr_target = mem[tos], combinationally, in the same cycle.
  - If count>0: tos <= tos-1 mod DEPTH; count <= count-1.
  - If count==0: no state change; o_jr_target_valid=0, so fetch must not use the target.
- **Pop+push** (jal and jr in the same valid cycle): o_jr_target = mem[tos] as for a pop; then mem[tos] <= ra.
  - tos and count are unchanged, except that when count==0 it becomes push-only behaviour (tos+1, count=1).
- **Checkpoint**: ck_tos and ck_count capture the next-state tos and count, i.e. the values after any same-cycle push or pop.
  - A later checkpoint overwrites the earlier one; there is one level only.
- **Restore**: tos <= ck_tos; count <= ck_count.
  - Restore overrides any same-cycle push, pop or checkpoint; none of those take effect.
  - mem is never restored. Entries overwritten since the checkpoint are stale, which is accepted prediction inaccuracy.
- **Priority**: i_reset > i_restore > (push/pop, then checkpoint capture).

## Timing
- o_jr_target, o_jr_target_valid, o_empty, o_full and o_count are combinational from registered state. There are no input-to-output combinational paths.
- A `jr` therefore reads the top as it stood before this edge. The pop takes effect at the next edge.
- Push latency: a value pushed at edge N is readable as o_jr_target in the cycle after edge N.
- Back-to-back push/pop on consecutive cycles needs no stall. Throughput is one event per cycle.
- Reset asserted mid-sequence clears everything at that edge and discards any same-cycle event.

## Test plan
- **Reset**: hold i_reset 2 cycles → o_count=0, o_empty=1, o_jr_target_valid=0, o_jr_target=0.
- **Push/pop order**: jal at 0x000100, then jal at 0x000200 → o_count=2, o_jr_target=0x000202. jr → target 0x000202 that cycle; next cycle o_jr_target=0x000102, o_count=1.
- **Overflow**: 9 jals at 0x10,0x20,…,0x90 with DEPTH=8 → o_full=1, o_count=8. Eight jrs return 0x92,0x82,…,0x22, one per cycle. A ninth jr sees o_jr_target_valid=0 and o_count stays 0.
- **Address wrap**: jal at 0x3FFFFF → o_jr_target=0x000001.
- **Checkpoint/restore**: two pushes (0x10, 0x20), checkpoint, pop, push 0x50, then restore → o_count=2, tos as at checkpoint. o_jr_target=0x52 (stale overwrite, expected).
- **Simultaneous events**: i_restore together with a jal → jal ignored, o_count equals ck_count. jal+jr on a stack holding 0x12 with i_branch_address=0x40 → target 0x12 that cycle; next cycle o_jr_target=0x42 and o_count unchanged.
